lbp_hist: RTL and testbench

LBP_HIST -- requirements
Module: lbp_hist

---
 rtl/lbp_hist_pkg.sv | 15 +
 rtl/lbp_hist_bank.sv | 33 +++
 rtl/lbp_hist.sv | 120 ++++++++++++
 tb/tb_lbp_hist.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_hist_pkg.sv
// lbp_hist shared definitions
// sizes and FSM state encoding
package lbp_hist_pkg;
  localparam int IMG_W  = 128;
  localparam int CNT_W  = 14;
  localparam int NBINS  = 256;
  localparam int ADDR_W = 14;
  localparam int CODE_W = 8;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/lbp_hist_bank.sv
// lbp_hist_bank: 256 saturating bin counters
// one increment port, clear-all, async read
module lbp_hist_bank #(
  parameter int CNT_W = lbp_hist_pkg::CNT_W,
  parameter int NBINS = lbp_hist_pkg::NBINS
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [7:0]       i_inc_idx,
  input  logic [7:0]       i_rd_idx,
  output logic [CNT_W-1:0] o_rd_data
);

  localparam logic [CNT_W-1:0] MAXV = '1;

  logic [CNT_W-1:0] r_bins [NBINS];

  // clear all bins, or bump one bin unless already full
  always_ff @(posedge clk) begin
    if (i_rst || i_clr) begin
      for (int k = 0; k < NBINS; k++) begin
        r_bins[k] <= '0;
      end
    end else if (i_inc && (r_bins[i_inc_idx] != MAXV)) begin
      r_bins[i_inc_idx] <= r_bins[i_inc_idx] + CNT_W'(1);
    end
  end

  assign o_rd_data = r_bins[i_rd_idx];

endmodule

// File: rtl/lbp_hist.sv
// lbp_hist: LBP code histogram with drain
// accumulate interior samples, stream bins out
module lbp_hist #(
  parameter int IMG_W = lbp_hist_pkg::IMG_W,
  parameter int CNT_W = lbp_hist_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lbp_valid,
  input  logic [13:0]      lbp_addr,
  input  logic [7:0]       lbp_data,
  input  logic             finish,
  input  logic             hist_ready,
  input  logic             hist_clear,
  output logic             hist_valid,
  output logic [7:0]       hist_addr,
  output logic [CNT_W-1:0] hist_data,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             hist_done,
  output logic             late_err
);

  import lbp_hist_pkg::*;

  localparam logic [CNT_W-1:0] MAXV = '1;
  localparam logic [13:0] LAST_RC = 14'(IMG_W - 2);

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_late;

  logic [13:0]      w_row;
  logic [13:0]      w_col;
  logic             w_inner;
  logic             w_accept;
  logic             w_drain;
  logic             w_take;
  logic             w_clr;
  logic [CNT_W-1:0] w_rd;

  assign w_row   = lbp_addr / 14'(IMG_W);
  assign w_col   = lbp_addr % 14'(IMG_W);
  assign w_inner = (w_row >= 14'd1) && (w_row <= LAST_RC)
                && (w_col >= 14'd1) && (w_col <= LAST_RC);

  assign w_accept = (r_state == ACCUM) && lbp_valid && w_inner;
  assign w_drain  = (r_state == DRAIN);
  assign w_take   = w_drain && hist_ready;
  assign w_clr    = (r_state == DONE) && hist_clear;

  lbp_hist_bank #(
    .CNT_W (CNT_W),
    .NBINS (NBINS)
  ) u_bank (
    .clk       (clk),
    .i_rst     (reset),
    .i_clr     (w_clr),
    .i_inc     (w_accept),
    .i_inc_idx (lbp_data),
    .i_rd_idx  (r_idx),
    .o_rd_data (w_rd)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ACCUM: if (finish) w_next = DRAIN;
      DRAIN: if (w_take && (r_idx == 8'hFF)) w_next = DONE;
      DONE:  if (hist_clear) w_next = ACCUM;
      default: w_next = ACCUM;
    endcase
  end

  // drain index, wraps to 0 after the last bin
  always_ff @(posedge clk) begin
    if (reset || w_clr) begin
      r_idx <= '0;
    end else if (w_take) begin
      r_idx <= r_idx + 8'd1;
    end
  end

  // saturating accepted-sample counter
  always_ff @(posedge clk) begin
    if (reset || w_clr) begin
      r_cnt <= '0;
    end else if (w_accept && (r_cnt != MAXV)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // sticky flag for samples arriving after ACCUM
  always_ff @(posedge clk) begin
    if (reset || w_clr) begin
      r_late <= 1'b0;
    end else if (lbp_valid && (r_state != ACCUM)) begin
      r_late <= 1'b1;
    end
  end

  assign hist_valid = w_drain;
  assign hist_addr  = w_drain ? r_idx : 8'd0;
  assign hist_data  = w_drain ? w_rd : '0;
  assign hist_done  = (r_state == DONE);
  assign sample_cnt = r_cnt;
  assign late_err   = r_late;

endmodule

// File: tb/tb_lbp_hist.sv
// tb_lbp_hist: directed checks for lbp_hist
// one task per scenario, inline comparisons
module tb_lbp_hist;

  logic        clk;
  logic        reset;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;
  logic        hist_ready;
  logic        hist_clear;
  logic        hist_valid;
  logic [7:0]  hist_addr;
  logic [13:0] hist_data;
  logic [13:0] sample_cnt;
  logic        hist_done;
  logic        late_err;

  int checks;
  int errors;

  lbp_hist dut (
    .clk        (clk),
    .reset      (reset),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .hist_ready (hist_ready),
    .hist_clear (hist_clear),
    .hist_valid (hist_valid),
    .hist_addr  (hist_addr),
    .hist_data  (hist_data),
    .sample_cnt (sample_cnt),
    .hist_done  (hist_done),
    .late_err   (late_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_frame();
    hist_clear = 1'b1;
    tick();
    hist_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({hist_valid, hist_done, late_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000",
               {hist_valid, hist_done, late_err});
    end
    checks++;
    if ({hist_addr, hist_data, sample_cnt} !== 36'd0) begin
      errors++;
      $display("FAIL reset_vals: addr %0d data %0d cnt %0d want 0",
               hist_addr, hist_data, sample_cnt);
    end
  endtask

  task automatic test_basic();
    logic [13:0] exp;
    lbp_data  = 8'h5A;
    lbp_valid = 1'b1;
    lbp_addr  = 14'd129;
    tick();
    lbp_addr  = 14'd130;
    tick();
    lbp_addr  = 14'd131;
    finish    = 1'b1;
    tick();
    lbp_valid = 1'b0;
    finish    = 1'b0;
    checks++;
    if (sample_cnt !== 14'd3) begin
      errors++;
      $display("FAIL basic_cnt: got %0d want 3", sample_cnt);
    end
    hist_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      exp = (i == 8'h5A) ? 14'd3 : 14'd0;
      checks++;
      if (!hist_valid || hist_addr !== 8'(i) || hist_data !== exp) begin
        errors++;
        $display("FAIL basic_bin%0d: v %b addr %0d data %0d want %0d",
                 i, hist_valid, hist_addr, hist_data, exp);
      end
      tick();
    end
    hist_ready = 1'b0;
    checks++;
    if ({hist_done, hist_valid} !== 2'b10) begin
      errors++;
      $display("FAIL basic_done: done/valid %b want 10",
               {hist_done, hist_valid});
    end
    clear_frame();
  endtask

  task automatic test_border();
    logic [13:0] addrs [4];
    addrs[0] = 14'd0;
    addrs[1] = 14'd127;
    addrs[2] = 14'd128;
    addrs[3] = 14'd16383;
    lbp_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      lbp_addr = addrs[k];
      lbp_data = 8'(k + 1);
      tick();
    end
    lbp_valid = 1'b0;
    finish    = 1'b1;
    tick();
    finish    = 1'b0;
    checks++;
    if (sample_cnt !== 14'd0) begin
      errors++;
      $display("FAIL border_cnt: got %0d want 0", sample_cnt);
    end
    hist_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (hist_data !== 14'd0) begin
        errors++;
        $display("FAIL border_bin%0d: got %0d want 0", i, hist_data);
      end
      tick();
    end
    hist_ready = 1'b0;
    clear_frame();
  endtask

  task automatic test_full_frame();
    logic [13:0] exp;
    lbp_valid = 1'b1;
    lbp_data  = 8'hFF;
    for (int r = 1; r <= 126; r++) begin
      for (int c = 1; c <= 126; c++) begin
        lbp_addr = 14'(r * 128 + c);
        tick();
      end
    end
    lbp_valid = 1'b0;
    finish    = 1'b1;
    tick();
    finish    = 1'b0;
    checks++;
    if (sample_cnt !== 14'd15876) begin
      errors++;
      $display("FAIL full_cnt: got %0d want 15876", sample_cnt);
    end
    hist_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      exp = (i == 255) ? 14'd15876 : 14'd0;
      checks++;
      if (hist_data !== exp) begin
        errors++;
        $display("FAIL full_bin%0d: got %0d want %0d",
                 i, hist_data, exp);
      end
      tick();
    end
    hist_ready = 1'b0;
    clear_frame();
  endtask

  task automatic test_saturate();
    logic [13:0] exp;
    lbp_valid = 1'b1;
    lbp_data  = 8'd7;
    lbp_addr  = 14'd129;
    for (int n = 0; n < 16400; n++) begin
      tick();
    end
    lbp_valid = 1'b0;
    finish    = 1'b1;
    tick();
    finish    = 1'b0;
    checks++;
    if (sample_cnt !== 14'd16383) begin
      errors++;
      $display("FAIL sat_cnt: got %0d want 16383", sample_cnt);
    end
    hist_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      exp = (i == 7) ? 14'd16383 : 14'd0;
      checks++;
      if (hist_data !== exp) begin
        errors++;
        $display("FAIL sat_bin%0d: got %0d want %0d",
                 i, hist_data, exp);
      end
      tick();
    end
    hist_ready = 1'b0;
    clear_frame();
  endtask

  task automatic test_handshake();
    hist_ready = 1'b0;
    finish     = 1'b1;
    tick();
    checks++;
    if (!hist_valid || hist_addr !== 8'd0) begin
      errors++;
      $display("FAIL hs_start: v %b addr %0d want 1/0",
               hist_valid, hist_addr);
    end
    hist_ready = 1'b1;
    tick();
    checks++;
    if (hist_addr !== 8'd1) begin
      errors++;
      $display("FAIL hs_adv0: got %0d want 1", hist_addr);
    end
    hist_ready = 1'b0;
    hist_clear = 1'b1;
    tick();
    hist_clear = 1'b0;
    checks++;
    if (!hist_valid || hist_addr !== 8'd1) begin
      errors++;
      $display("FAIL hs_hold1: v %b addr %0d want 1/1",
               hist_valid, hist_addr);
    end
    tick();
    checks++;
    if (hist_addr !== 8'd1) begin
      errors++;
      $display("FAIL hs_hold2: got %0d want 1", hist_addr);
    end
    hist_ready = 1'b1;
    tick();
    checks++;
    if (hist_addr !== 8'd2) begin
      errors++;
      $display("FAIL hs_adv1: got %0d want 2", hist_addr);
    end
    for (int i = 2; i < 255; i++) begin
      tick();
    end
    checks++;
    if (!hist_valid || hist_addr !== 8'd255) begin
      errors++;
      $display("FAIL hs_last: v %b addr %0d want 1/255",
               hist_valid, hist_addr);
    end
    tick();
    hist_ready = 1'b0;
    checks++;
    if ({hist_done, hist_valid} !== 2'b10) begin
      errors++;
      $display("FAIL hs_done: done/valid %b want 10",
               {hist_done, hist_valid});
    end
    tick();
    checks++;
    if ({hist_done, hist_valid} !== 2'b10) begin
      errors++;
      $display("FAIL hs_finish_hi: done/valid %b want 10",
               {hist_done, hist_valid});
    end
    finish = 1'b0;
    clear_frame();
  endtask

  task automatic test_late_err();
    logic [13:0] exp;
    lbp_valid = 1'b1;
    lbp_addr  = 14'd129;
    lbp_data  = 8'd3;
    tick();
    lbp_valid = 1'b0;
    finish    = 1'b1;
    tick();
    finish    = 1'b0;
    checks++;
    if (late_err !== 1'b0) begin
      errors++;
      $display("FAIL late_pre: got %b want 0", late_err);
    end
    lbp_valid = 1'b1;
    lbp_addr  = 14'd130;
    tick();
    lbp_valid = 1'b0;
    checks++;
    if (late_err !== 1'b1 || sample_cnt !== 14'd1) begin
      errors++;
      $display("FAIL late_set: err %b cnt %0d want 1/1",
               late_err, sample_cnt);
    end
    hist_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      exp = (i == 3) ? 14'd1 : 14'd0;
      checks++;
      if (hist_data !== exp) begin
        errors++;
        $display("FAIL late_bin%0d: got %0d want %0d",
                 i, hist_data, exp);
      end
      tick();
    end
    hist_ready = 1'b0;
    checks++;
    if ({hist_done, late_err} !== 2'b11) begin
      errors++;
      $display("FAIL late_done: done/err %b want 11",
               {hist_done, late_err});
    end
    clear_frame();
    checks++;
    if ({hist_done, late_err, hist_valid} !== 3'b000
        || sample_cnt !== 14'd0) begin
      errors++;
      $display("FAIL late_clr: d/e/v %b cnt %0d want 000/0",
               {hist_done, late_err, hist_valid}, sample_cnt);
    end
    finish = 1'b1;
    tick();
    finish = 1'b0;
    hist_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (!hist_valid || hist_data !== 14'd0) begin
        errors++;
        $display("FAIL clr_bin%0d: v %b got %0d want 0",
                 i, hist_valid, hist_data);
      end
      tick();
    end
    hist_ready = 1'b0;
    clear_frame();
  endtask

  task automatic test_reset_mid_drain();
    lbp_valid = 1'b1;
    lbp_addr  = 14'd129;
    lbp_data  = 8'd0;
    tick();
    lbp_valid = 1'b0;
    finish    = 1'b1;
    tick();
    finish    = 1'b0;
    checks++;
    if (hist_data !== 14'd1) begin
      errors++;
      $display("FAIL rmd_bin0: got %0d want 1", hist_data);
    end
    hist_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
    end
    checks++;
    if (hist_addr !== 8'd100) begin
      errors++;
      $display("FAIL rmd_addr: got %0d want 100", hist_addr);
    end
    reset     = 1'b1;
    lbp_valid = 1'b1;
    lbp_addr  = 14'd130;
    finish    = 1'b1;
    tick();
    reset      = 1'b0;
    lbp_valid  = 1'b0;
    finish     = 1'b0;
    hist_ready = 1'b0;
    checks++;
    if ({hist_valid, hist_done, late_err} !== 3'b000
        || hist_addr !== 8'd0 || hist_data !== 14'd0
        || sample_cnt !== 14'd0) begin
      errors++;
      $display("FAIL rmd_reset: v/d/e %b addr %0d data %0d cnt %0d",
               {hist_valid, hist_done, late_err},
               hist_addr, hist_data, sample_cnt);
    end
    finish = 1'b1;
    tick();
    finish = 1'b0;
    checks++;
    if (!hist_valid || hist_addr !== 8'd0 || hist_data !== 14'd0) begin
      errors++;
      $display("FAIL rmd_redrain: v %b addr %0d data %0d want 1/0/0",
               hist_valid, hist_addr, hist_data);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    lbp_valid  = 1'b0;
    lbp_addr   = '0;
    lbp_data   = '0;
    finish     = 1'b0;
    hist_ready = 1'b0;
    hist_clear = 1'b0;
    test_reset();
    test_basic();
    test_border();
    test_full_frame();
    test_saturate();
    test_handshake();
    test_late_err();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
